// File: rtl/control_unit.sv
// control_unit -- single-cycle ARM-subset main decoder with conditional execution.
//
// Purpose:
//   Decodes the current instruction word into datapath control signals,
//   holds the {N,Z,C,V} condition flags and gates every architectural write
//   (register file, data memory, PC) with the instruction's condition field.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset (asserted when 0)
//   Instr      in   [31:0] current instruction word
//   ALUFlags   in   [3:0]  {N,Z,C,V} produced by the ALU this cycle
//   RegSrc     out  [1:0]  register-address mux selects
//   RegWrite   out         register file write enable
//   ImmSrc     out  [1:0]  extend unit select
//   ALUSrc     out         SrcB select (1 = ExtImm)
//   ALUControl out  [1:0]  00 ADD, 01 SUB, 10 AND, 11 ORR
//   MemtoReg   out         result select (1 = ReadData)
//   MemWrite   out         data memory write enable
//   PCSrc      out         PC mux select (1 = Result)
//   Trap       out         sticky illegal-instruction flag (CONTROL_UNIT_TRAP_EN only)
//
// Configuration:
//   CONTROL_UNIT_TRAP_EN -- when defined, an illegal instruction sets a sticky
//   Trap flag that blocks all writes and flag updates until reset. When not
//   defined, illegal instructions are plain no-ops.

module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        PCSrc
`ifdef CONTROL_UNIT_TRAP_EN
  ,
  output logic        Trap
`endif
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = Instr[24:21];
  assign rd    = Instr[15:12];

  // Register-number and immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       dp_legal;
  logic       illegal;
  logic       pcs;
  logic       cond_ex;
  logic       trap_active;
  logic       write_en;
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  // Main decode
  always_comb begin
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    dp_legal   = 1'b0;
    illegal    = 1'b0;
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    ALUSrc     = 1'b0;
    ALUControl = 2'b00;
    MemtoReg   = 1'b0;
    case (op)
      2'b00: begin
        ALUSrc = funct[5];
        case (cmd)
          4'b0100: begin ALUControl = 2'b00; reg_w = 1'b1; dp_legal = 1'b1; end
          4'b0010: begin ALUControl = 2'b01; reg_w = 1'b1; dp_legal = 1'b1; end
          4'b0000: begin ALUControl = 2'b10; reg_w = 1'b1; dp_legal = 1'b1; end
          4'b1100: begin ALUControl = 2'b11; reg_w = 1'b1; dp_legal = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      2'b01: begin
        ALUSrc = 1'b1;
        ImmSrc = 2'b01;
        if (funct[0]) begin
          reg_w    = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          mem_w  = 1'b1;
          RegSrc = 2'b10;
        end
      end
      2'b10: begin
        branch = 1'b1;
        ImmSrc = 2'b10;
        ALUSrc = 1'b1;
        RegSrc = 2'b01;
      end
      default: illegal = 1'b1;
    endcase
  end

  // A register write to R15 is a jump.
  assign pcs = branch | (reg_w & (rd == 4'b1111));

  // Condition check uses only the registered flags of the previous instruction.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

`ifdef CONTROL_UNIT_TRAP_EN
  logic trap_q;
  logic trap_d;

  // Set by any illegal decode, independent of the condition outcome.
  always_comb begin
    trap_d = trap_q | illegal;
  end

  always_ff @(posedge clk) begin
    if (!reset) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign trap_active = trap_q;
  assign Trap        = trap_q;
`else
  assign trap_active = 1'b0;
`endif

  // Reset and trap both suppress every architectural side effect.
  assign write_en = cond_ex & reset & ~trap_active;

  assign RegWrite = reg_w & write_en;
  assign MemWrite = mem_w & write_en;
  assign PCSrc    = pcs & write_en;

  // Logical ops leave C and V untouched.
  always_comb begin
    flags_d = flags_q;
    if (dp_legal && Instr[20] && cond_ex && !trap_active) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (ALUControl == 2'b00 || ALUControl == 2'b01) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit. Inputs change on the falling edge,
// outputs are checked 1 ns later, and flag updates land on the rising edge.

module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        MemWrite;
  logic        PCSrc;
`ifdef CONTROL_UNIT_TRAP_EN
  logic        Trap;
`endif

  int vec_count = 0;
  int err_count = 0;

  localparam logic [31:0] I_SUBS   = 32'hE2511001;
  localparam logic [31:0] I_BEQ    = 32'h0A000002;
  localparam logic [31:0] I_ORR    = 32'hE1832004;
  localparam logic [31:0] I_LDR    = 32'hE5965008;
  localparam logic [31:0] I_STR    = 32'hE5865008;
  localparam logic [31:0] I_ADDPC  = 32'hE28FF004;
  localparam logic [31:0] I_ANDS   = 32'hE2100000;
  localparam logic [31:0] I_MOV    = 32'hE1A00000;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemtoReg   (MemtoReg),
    .MemWrite   (MemWrite),
    .PCSrc      (PCSrc)
`ifdef CONTROL_UNIT_TRAP_EN
    ,
    .Trap       (Trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: apply inputs on the falling edge, settle, log.
  task automatic drive(input logic rst, input logic [31:0] ins, input logic [3:0] fl);
    @(negedge clk);
    reset    = rst;
    Instr    = ins;
    ALUFlags = fl;
    #1;
    $display("t=%0t reset=%b instr=%h aluflags=%b -> regw=%b memw=%b pcsrc=%b aluctl=%b",
             $time, rst, ins, fl, RegWrite, MemWrite, PCSrc, ALUControl);
  endtask

  task automatic test_reset();
    drive(1'b0, I_ADDPC, 4'b0000);
    vec_count++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
      err_count++;
      $display("FAIL reset_gating: got %b, want 000", {PCSrc, RegWrite, MemWrite});
    end
    vec_count++;
    if ({ALUControl, ALUSrc, ImmSrc} !== 5'b00100) begin
      err_count++;
      $display("FAIL reset_decode: got %b, want 00100", {ALUControl, ALUSrc, ImmSrc});
    end
    drive(1'b0, I_STR, 4'b0000);
    vec_count++;
    if ({MemWrite, RegSrc} !== 3'b010) begin
      err_count++;
      $display("FAIL reset_str: got %b, want 010", {MemWrite, RegSrc});
    end
`ifdef CONTROL_UNIT_TRAP_EN
    vec_count++;
    if (Trap !== 1'b0) begin
      err_count++;
      $display("FAIL reset_trap: got %b, want 0", Trap);
    end
`endif
    drive(1'b1, I_BEQ, 4'b0000);
    vec_count++;
    if (PCSrc !== 1'b0) begin
      err_count++;
      $display("FAIL reset_flags_clear: got %b, want 0", PCSrc);
    end
  endtask

  task automatic test_subs_beq();
    drive(1'b1, I_SUBS, 4'b0100);
    vec_count++;
    if ({ALUControl, ALUSrc, RegWrite} !== 4'b0111) begin
      err_count++;
      $display("FAIL subs_decode: got %b, want 0111", {ALUControl, ALUSrc, RegWrite});
    end
    drive(1'b1, I_BEQ, 4'b0000);
    vec_count++;
    if ({PCSrc, ImmSrc} !== 3'b110) begin
      err_count++;
      $display("FAIL beq_taken: got %b, want 110", {PCSrc, ImmSrc});
    end
  endtask

  task automatic test_orr_no_flags();
    drive(1'b1, I_SUBS, 4'b0000);
    drive(1'b1, I_ORR, 4'b1111);
    vec_count++;
    if ({ALUControl, ALUSrc, RegWrite} !== 4'b1101) begin
      err_count++;
      $display("FAIL orr_decode: got %b, want 1101", {ALUControl, ALUSrc, RegWrite});
    end
    drive(1'b1, I_BEQ, 4'b0000);
    vec_count++;
    if (PCSrc !== 1'b0) begin
      err_count++;
      $display("FAIL orr_no_flag_update: got %b, want 0", PCSrc);
    end
  endtask

  task automatic test_mem();
    drive(1'b1, I_LDR, 4'b0000);
    vec_count++;
    if ({MemtoReg, ImmSrc, RegWrite, MemWrite} !== 5'b10110) begin
      err_count++;
      $display("FAIL ldr_decode: got %b, want 10110", {MemtoReg, ImmSrc, RegWrite, MemWrite});
    end
    vec_count++;
    if ({ALUSrc, ALUControl, RegSrc} !== 5'b10000) begin
      err_count++;
      $display("FAIL ldr_path: got %b, want 10000", {ALUSrc, ALUControl, RegSrc});
    end
    drive(1'b1, I_STR, 4'b0000);
    vec_count++;
    if ({MemWrite, RegWrite, RegSrc, MemtoReg} !== 5'b10100) begin
      err_count++;
      $display("FAIL str_decode: got %b, want 10100", {MemWrite, RegWrite, RegSrc, MemtoReg});
    end
  endtask

  task automatic test_pc_write();
    drive(1'b1, I_ADDPC, 4'b0000);
    vec_count++;
    if ({PCSrc, RegWrite, ALUControl} !== 4'b1100) begin
      err_count++;
      $display("FAIL add_pc: got %b, want 1100", {PCSrc, RegWrite, ALUControl});
    end
  endtask

  // Each row: flags loaded via SUBS, then the 16 condition codes as branches.
  // Mask bit c is the hand-evaluated outcome of condition c for those flags.
  task automatic test_cond_table();
    logic [3:0]  flag_tab [6];
    logic [15:0] mask_tab [6];
    logic [15:0] m;
    logic [31:0] ins;
    flag_tab = '{4'b0000, 4'b0100, 4'b1010, 4'b0011, 4'b1001, 4'b1110};
    mask_tab = '{16'h56AA, 16'h66A9, 16'h6996, 16'h6966, 16'h565A, 16'h6A95};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, I_SUBS, flag_tab[i]);
      m = mask_tab[i];
      for (int c = 0; c < 16; c++) begin
        ins = {c[3:0], 28'hA000002};
        drive(1'b1, ins, 4'b0000);
        vec_count++;
        if (PCSrc !== m[c]) begin
          err_count++;
          $display("FAIL cond_%0d_flags_%b: got %b, want %b", c, flag_tab[i], PCSrc, m[c]);
        end
      end
    end
  endtask

  // ANDS loads N,Z but keeps C,V from the earlier SUBS.
  task automatic test_logic_cv();
    logic [3:0] conds [4];
    logic [31:0] ins;
    conds = '{4'h2, 4'h6, 4'h0, 4'h4};
    drive(1'b1, I_SUBS, 4'b0011);
    drive(1'b1, I_ANDS, 4'b1100);
    vec_count++;
    if ({ALUControl, RegWrite} !== 3'b101) begin
      err_count++;
      $display("FAIL ands_decode: got %b, want 101", {ALUControl, RegWrite});
    end
    for (int k = 0; k < 4; k++) begin
      ins = {conds[k], 28'hA000002};
      drive(1'b1, ins, 4'b0000);
      vec_count++;
      if (PCSrc !== 1'b1) begin
        err_count++;
        $display("FAIL ands_keep_cv_cond_%0h: got %b, want 1", conds[k], PCSrc);
      end
    end
  endtask

  task automatic test_cond_fail();
    drive(1'b1, I_SUBS, 4'b0000);
    drive(1'b1, 32'h02511001, 4'b0100);
    vec_count++;
    if ({RegWrite, ALUControl, ALUSrc} !== 4'b0011) begin
      err_count++;
      $display("FAIL subseq_skipped: got %b, want 0011", {RegWrite, ALUControl, ALUSrc});
    end
    drive(1'b1, 32'h05865008, 4'b0000);
    vec_count++;
    if ({MemWrite, RegSrc, ImmSrc} !== 5'b01001) begin
      err_count++;
      $display("FAIL streq_skipped: got %b, want 01001", {MemWrite, RegSrc, ImmSrc});
    end
    drive(1'b1, I_BEQ, 4'b0000);
    vec_count++;
    if (PCSrc !== 1'b0) begin
      err_count++;
      $display("FAIL skipped_no_flag_update: got %b, want 0", PCSrc);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, I_SUBS, 4'b0100);
    drive(1'b0, I_ADDPC, 4'b0000);
    vec_count++;
    if ({PCSrc, RegWrite} !== 2'b00) begin
      err_count++;
      $display("FAIL midreset_gating: got %b, want 00", {PCSrc, RegWrite});
    end
    // A flag-setting SUBS held in reset must not load N.
    drive(1'b0, I_SUBS, 4'b1000);
    drive(1'b1, I_BEQ, 4'b0000);
    vec_count++;
    if (PCSrc !== 1'b0) begin
      err_count++;
      $display("FAIL midreset_z_cleared: got %b, want 0", PCSrc);
    end
    drive(1'b1, 32'h4A000002, 4'b0000);
    vec_count++;
    if (PCSrc !== 1'b0) begin
      err_count++;
      $display("FAIL midreset_update_discarded: got %b, want 0", PCSrc);
    end
  endtask

  task automatic test_illegal();
    logic exp_pc;
    drive(1'b1, I_SUBS, 4'b0000);
    drive(1'b1, 32'hE1B00000, 4'b0100);
    vec_count++;
    if ({RegWrite, MemWrite, PCSrc} !== 3'b000) begin
      err_count++;
      $display("FAIL illegal_dp_writes: got %b, want 000", {RegWrite, MemWrite, PCSrc});
    end
    drive(1'b1, I_BEQ, 4'b0000);
    vec_count++;
    if (PCSrc !== 1'b0) begin
      err_count++;
      $display("FAIL illegal_dp_no_flags: got %b, want 0", PCSrc);
    end
    drive(1'b1, 32'hEC00F000, 4'b0000);
    vec_count++;
    if ({RegWrite, MemWrite, PCSrc} !== 3'b000) begin
      err_count++;
      $display("FAIL illegal_op11: got %b, want 000", {RegWrite, MemWrite, PCSrc});
    end
`ifdef CONTROL_UNIT_TRAP_EN
    exp_pc = 1'b0;
`else
    exp_pc = 1'b1;
`endif
    drive(1'b1, I_ADDPC, 4'b0000);
    vec_count++;
    if (PCSrc !== exp_pc) begin
      err_count++;
      $display("FAIL after_illegal_add_pc: got %b, want %b", PCSrc, exp_pc);
    end
  endtask

`ifdef CONTROL_UNIT_TRAP_EN
  task automatic test_trap();
    drive(1'b0, I_ADDPC, 4'b0000);
    // Condition EQ is false (flags cleared), the trap must still fire.
    drive(1'b1, 32'h01A00000, 4'b0000);
    vec_count++;
    if (Trap !== 1'b0) begin
      err_count++;
      $display("FAIL trap_not_yet: got %b, want 0", Trap);
    end
    drive(1'b1, I_ADDPC, 4'b0000);
    vec_count++;
    if ({Trap, PCSrc, RegWrite} !== 3'b100) begin
      err_count++;
      $display("FAIL trap_blocks: got %b, want 100", {Trap, PCSrc, RegWrite});
    end
    drive(1'b1, I_STR, 4'b0000);
    drive(1'b1, I_LDR, 4'b0000);
    vec_count++;
    if ({Trap, MemWrite, RegWrite} !== 3'b100) begin
      err_count++;
      $display("FAIL trap_sticky: got %b, want 100", {Trap, MemWrite, RegWrite});
    end
    drive(1'b0, I_MOV, 4'b0000);
    drive(1'b1, I_ADDPC, 4'b0000);
    vec_count++;
    if ({Trap, PCSrc, RegWrite} !== 3'b011) begin
      err_count++;
      $display("FAIL trap_cleared: got %b, want 011", {Trap, PCSrc, RegWrite});
    end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    Instr    = I_ADDPC;
    ALUFlags = 4'b0000;
    test_reset();
    test_subs_beq();
    test_orr_no_flags();
    test_mem();
    test_pc_write();
    test_cond_table();
    test_logic_cv();
    test_cond_fail();
    test_reset_midstream();
    test_illegal();
`ifdef CONTROL_UNIT_TRAP_EN
    test_trap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL expose these ports, clock and reset first:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-low reset (asserted when 0)
  Instr  in  32  current instruction word
  ALUFlags  in  4  datapath flags {N,Z,C,V}, bit3=N .. bit0=V
  RegSrc  out  2  register-address mux selects
  RegWrite  out  1  register file write enable
  ImmSrc  out  2  extend unit select
  ALUSrc  out  1  SrcB select (1=ExtImm)
  ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
  MemtoReg  out  1  result select (1=ReadData)
  MemWrite  out  1  data memory write enable
  PCSrc  out  1  PC mux select (1=Result)
  Trap  out  1  sticky illegal-instruction flag (only with CONTROL_UNIT_TRAP_EN)
REQ-002 There SHALL be one clock domain, clk, and no parameters.

Function
REQ-003 Decode SHALL be combinational from Instr[27:26] (Op), Instr[25:20] (Funct) and Instr[15:12] (Rd).
REQ-004 Op=00 data-processing: RegW=1; ALUSrc=Funct[5]; ImmSrc=00; RegSrc=00; MemtoReg=0; MemW=0.
REQ-005 DP cmd Instr[24:21]: 0100 gives ALUControl=00, 0010 gives 01, 0000 gives 10, 1100 gives 11; any other cmd is illegal: RegW=0, no flag update.
REQ-006 Op=01 memory: ALUSrc=1; ImmSrc=01; ALUControl=00. If Funct[0]=1 (LDR): RegW=1, MemtoReg=1, RegSrc=00. If Funct[0]=0 (STR): MemW=1, RegW=0, RegSrc=10.
REQ-007 Op=10 branch: Branch=1; ImmSrc=10; ALUSrc=1; RegSrc=01; ALUControl=00; RegW=0; MemW=0.
REQ-008 Op=11 SHALL be illegal and decode to no writes and no branch.
REQ-009 PCS SHALL equal Branch OR (RegW AND Rd=1111).
REQ-010 A 4-bit flag register {N,Z,C,V} SHALL hold condition state; CondEx SHALL be evaluated from Instr[31:28] against the registered flags only (previous instruction's result), never against ALUFlags directly.
REQ-011 The conditions SHALL be: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL (0000-1110) with standard ARM meaning; 1111 is CondEx=0.
REQ-012 The outputs SHALL be gated: PCSrc=PCS AND CondEx; RegWrite=RegW AND CondEx; MemWrite=MemW AND CondEx.
REQ-013 Flag update SHALL occur on a rising edge only for a DP instruction with S=Instr[20]=1 and CondEx=1: N,Z always load from ALUFlags[3:2]; C,V load from ALUFlags[1:0] only for ADD or SUB.
REQ-014 When CondEx=0, the registered flags SHALL remain unchanged and RegSrc, ImmSrc, ALUSrc, ALUControl and MemtoReg SHALL still follow the decode.
REQ-015 Flags written by an instruction SHALL become visible to the condition of the next instruction, so the latency is one cycle.

Reset
REQ-016 On a clk edge with reset=0, flags SHALL clear to 0000 and Trap SHALL clear to 0.
REQ-017 While reset=0, RegWrite, MemWrite and PCSrc SHALL be forced to 0 regardless of Instr; all other outputs follow the decode.
REQ-018 A reset asserted mid-stream SHALL discard any pending flag update for that cycle.

Configuration
REQ-019 Macro CONTROL_UNIT_TRAP_EN SHALL control the Trap feature.
REQ-020 With CONTROL_UNIT_TRAP_EN defined: the Trap port exists; Trap is set on the edge after any illegal instruction (REQ-005/008) is decoded, whatever the condition outcome; Trap is sticky until reset; while Trap=1, RegWrite, MemWrite, PCSrc and flag updates are forced to 0.
REQ-021 Without CONTROL_UNIT_TRAP_EN: the Trap port is absent, and illegal instructions act as no-ops with no other effect.

Verification
REQ-022 Reset, then 0xE2511001 (SUBS R1,R1,#1) with ALUFlags=0100 -> ALUControl=01, ALUSrc=1, RegWrite=1. Next cycle 0x0A000002 (BEQ) -> PCSrc=1, ImmSrc=10.
REQ-023 Flags=0000, then 0xE1832004 (ORR R2,R3,R4) with ALUFlags=1111 -> ALUControl=11, ALUSrc=0, RegWrite=1, flags unchanged. Next cycle 0x0A000002 -> PCSrc=0.
REQ-024 0xE5965008 (LDR) -> MemtoReg=1, ImmSrc=01, RegWrite=1, MemWrite=0. 0xE5865008 (STR) -> MemWrite=1, RegWrite=0, RegSrc=10.
REQ-025 0xE28FF004 (ADD PC,PC,#4) -> PCSrc=1, RegWrite=1, ALUControl=00.
REQ-026 Set Z via SUBS, then hold reset=0 for one edge with 0xE28FF004 applied -> PCSrc=0 and RegWrite=0 during reset; afterwards 0x0A000002 -> PCSrc=0 (Z cleared).
REQ-027 With CONTROL_UNIT_TRAP_EN, apply 0xE1A00000 (cmd 1101) -> Trap=1 next cycle. A following 0xE28FF004 -> PCSrc=0 and RegWrite=0; Trap stays 1 until reset=0.
